alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//   Initiator side of the alu start/done handshake. Accepts 16-bit instructions,
//   reads operands from an internal 8x16 register file, and issues one operation to alu.
//   Waits for done, then writes the results back to the register file.
//   Sits between the instruction source and alu; it is the only driver of alu's start.
// PARAMETERS
//   TIMEOUT_CYCLES  64  maximum cycles spent in WAIT before the op is abandoned
//   RETIRE_W        16  width of the retired-instruction counter
// PORTS
//   clk          in   1   clock
//   reset        in   1   reset, asynchronous, active-high
//   instr_valid  in   1   instruction offered
//   instr        in   16  [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ignored
//   instr_ready  out  1   high only in IDLE; an instruction is accepted on valid&ready
//   ld_en        in   1   direct register-file write (initialisation/debug)
//   ld_addr      in   3   register written by ld_en
//   ld_data      in   16  data written by ld_en
//   rd_addr      in   3   debug read address
//   rd_data      out  16  regfile[rd_addr], combinational
//   alu_a/alu_b  out  16  operands, registered, held stable from ISSUE to end of WAIT
//   alu_opcode   out  3   operation, registered, held the same way as the operands
//   alu_start    out  1   single-cycle pulse in ISSUE
//   alu_res_lo   in   17  alu result_low; only [15:0] is used
//   alu_res_hi   in   17  alu result_high; only [15:0] is used
//   alu_done     in   1   alu completion pulse
//   busy         out  1   state != IDLE
//   err_illegal  out  1   one-cycle pulse when an op in 100..111 is accepted
//   err_timeout  out  1   sticky; cleared only by reset
//   retired      out  RETIRE_W  count of writebacks, wraps modulo 2^RETIRE_W
// BEHAVIOUR
//   Reset value of every output is 0. Registers, state and counters are also 0; state=IDLE.
//   FSM: IDLE -> ISSUE -> WAIT -> WB -> IDLE.
//   - IDLE: on accept, latch op/rd and operands regfile[rs1]/regfile[rs2] into alu_a/alu_b.
//     Ops 000 add, 001 sub, 010 mul and 011 div go to ISSUE.
//     Ops 1xx pulse err_illegal, stay in IDLE, and never assert alu_start.
//   - ISSUE: alu_start=1 for exactly one cycle; clear timeout counter; go to WAIT.
//   - WAIT: alu_start=0. On alu_done, capture res_lo[15:0] and res_hi[15:0], go to WB.
//     Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES:
//     set err_timeout, return to IDLE, no writeback, retired unchanged.
//   - WB: 000/001 write rd<=lo. 010/011 write rd<=lo and (rd+1 mod 8)<=hi.
//     For div, lo is the quotient and hi the remainder. retired+=1; go to IDLE.
//     The WB cycle also guarantees alu is back in its idle state before the next start.
//   Latency for add/sub: accept edge T, alu_start in T+1, alu_done in T+2,
//   regfile updated at end of T+3, instr_ready high again in T+4.
//   Peak throughput is 1 add/sub per 4 cycles.
//   Operands are sampled at accept. A later ld_en to rs1/rs2 does not change the op in flight.
//   ld_en is honoured in any state. If ld_en and a WB write hit the same register
//   in the same cycle, WB wins. ld_en never changes instr_ready.
//   rd=7 with mul/div: high half wraps to r0.
//   alu_done outside WAIT is ignored.
//   Reset mid-operation: asynchronous return to IDLE, alu_start drops immediately,
//   regfile cleared, no partial writeback.
// STRUCTURE
//   Shared package alu_pkg: opcode constants (OP_ADD..OP_DIV), instruction field
//   positions, and state encoding (IDLE/ISSUE/WAIT/WB, 2 bits).
//   One sub-module: issue_regfile, 8x16 with two combinational read ports plus the debug read port,
//   and two write ports (WB primary and secondary, ld) with the priority rule above.
//   FSM, timeout counter and retired counter live in the top module.
// TESTING (bench instantiates alu_issue_ctrl + alu)
//   1. ld r1=0x0005, r2=0x0003; add r0=r1+r2 -> alu_start pulse 1 cycle; r0=0x0008
//      at T+3; retired=1.
//   2. r1=0x1234, r2=0x0100; mul rd=r6 -> r6=0x3400, r7=0x0012; busy until WB;
//      instr_valid held high is not accepted until IDLE.
//   3. r3=100, r4=7; div rd=r7 -> r7=14 (quotient), r0=2 (remainder, wrapped); retired+1.
//   4. op=101 -> err_illegal 1-cycle pulse; alu_start never high; regfile unchanged.
//   5. Bench alu model withholds done -> err_timeout set after TIMEOUT_CYCLES in WAIT;
//      FSM back in IDLE; no register changed.
//   6. Same cycle as WB of add to r0=0x0008, ld_en r0=0xFFFF -> r0=0x0008.
//      Separately, assert reset during WAIT of a mul -> all outputs 0, IDLE next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu issue controller.
//   - opcode constants understood by alu (1xx encodings are illegal)
//   - instruction field layout
//   - register-file geometry
//   - issue FSM state encoding
package alu_pkg;

  localparam int REG_N  = 8;
  localparam int REG_AW = 3;
  localparam int REG_W  = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  // Instruction layout: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] unused.
  typedef struct packed {
    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [3:0]        rsvd;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  // Only the four arithmetic ops (0xx) are forwarded to alu.
  function automatic logic is_legal_op(input logic [2:0] op);
    return !op[2];
  endfunction

  // mul and div return two halves, so they write rd and rd+1.
  function automatic logic is_wide_op(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/issue_regfile.sv
// 8x16 register file for the alu issue controller.
//   Reads : two combinational operand ports (rs1/rs2) and one debug port.
//   Writes: wb  (primary writeback, rd)
//           wb2 (secondary writeback, rd+1 for mul/div high half)
//           ld  (direct load for initialisation/debug)
//   A writeback beats a same-cycle ld to the same register.
// Ports
//   clk, reset                 clock, asynchronous active-high reset (clears all)
//   i_rs1_addr/o_rs1_data      operand read port A
//   i_rs2_addr/o_rs2_data      operand read port B
//   i_dbg_addr/o_dbg_data      debug read port
//   i_wb_en/addr/data          primary write port
//   i_wb2_en/addr/data         secondary write port
//   i_ld_en/addr/data          load write port (lowest priority)
import alu_pkg::*;

module issue_regfile (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] i_rs1_addr,
  output logic [REG_W-1:0]  o_rs1_data,
  input  logic [REG_AW-1:0] i_rs2_addr,
  output logic [REG_W-1:0]  o_rs2_data,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [REG_W-1:0]  o_dbg_data,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [REG_W-1:0]  i_wb_data,
  input  logic              i_wb2_en,
  input  logic [REG_AW-1:0] i_wb2_addr,
  input  logic [REG_W-1:0]  i_wb2_data,
  input  logic              i_ld_en,
  input  logic [REG_AW-1:0] i_ld_addr,
  input  logic [REG_W-1:0]  i_ld_data
);

  logic [REG_W-1:0] r_mem [REG_N];

  assign o_rs1_data = r_mem[i_rs1_addr];
  assign o_rs2_data = r_mem[i_rs2_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

  // NOTE: this array is reset on purpose -- a reset must leave every register
  // at zero, which rules out mapping it onto a reset-less RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < REG_N; i++) begin
        // wb and wb2 never target the same register (rd vs rd+1).
        if (i_wb2_en && (i_wb2_addr == REG_AW'(i)))
          r_mem[i] <= i_wb2_data;
        else if (i_wb_en && (i_wb_addr == REG_AW'(i)))
          r_mem[i] <= i_wb_data;
        else if (i_ld_en && (i_ld_addr == REG_AW'(i)))
          r_mem[i] <= i_ld_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the alu start/done handshake.
// Accepts one instruction at a time, reads its operands from the internal
// register file, pulses alu_start, waits (bounded) for alu_done and writes the
// result(s) back. FSM: IDLE -> ISSUE -> WAIT -> WB -> IDLE.
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   instr_valid/instr/instr_ready   instruction handshake (ready only in IDLE)
//   ld_en/ld_addr/ld_data      direct register-file write, any state
//   rd_addr/rd_data            combinational debug read
//   alu_a/alu_b/alu_opcode     registered operands/op, stable ISSUE..WAIT
//   alu_start                  one-cycle pulse in ISSUE
//   alu_res_lo/alu_res_hi      alu results (bit 16 unused)
//   alu_done                   alu completion pulse, honoured only in WAIT
//   busy                       controller not idle
//   err_illegal                one-cycle pulse on accepting an op 1xx
//   err_timeout                sticky: alu never answered within TIMEOUT_CYCLES
//   retired                    writeback count, wraps
import alu_pkg::*;

module alu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RETIRE_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [15:0]         instr,
  output logic                instr_ready,
  input  logic                ld_en,
  input  logic [REG_AW-1:0]   ld_addr,
  input  logic [REG_W-1:0]    ld_data,
  input  logic [REG_AW-1:0]   rd_addr,
  output logic [REG_W-1:0]    rd_data,
  output logic [REG_W-1:0]    alu_a,
  output logic [REG_W-1:0]    alu_b,
  output logic [2:0]          alu_opcode,
  output logic                alu_start,
  input  logic [16:0]         alu_res_lo,
  input  logic [16:0]         alu_res_hi,
  input  logic                alu_done,
  output logic                busy,
  output logic                err_illegal,
  output logic                err_timeout,
  output logic [RETIRE_W-1:0] retired
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  instr_t            w_instr;
  logic [REG_W-1:0]  w_rs1_data;
  logic [REG_W-1:0]  w_rs2_data;
  logic              w_accept;
  logic              w_wb_en;
  logic              w_wb2_en;
  logic [REG_AW-1:0] w_wb2_addr;
  logic              w_unused;

  state_e            r_state;
  logic [REG_AW-1:0] r_rd;
  logic [REG_W-1:0]  r_alu_a;
  logic [REG_W-1:0]  r_alu_b;
  logic [2:0]        r_alu_opcode;
  logic              r_alu_start;
  logic              r_instr_ready;
  logic              r_busy;
  logic              r_err_illegal;
  logic              r_err_timeout;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [REG_W-1:0]  r_res_lo;
  logic [REG_W-1:0]  r_res_hi;
  logic [RETIRE_W-1:0] r_retired;

  assign w_instr  = instr_t'(instr);
  assign w_accept = instr_valid && r_instr_ready;
  assign w_unused = ^{alu_res_lo[16], alu_res_hi[16], w_instr.rsvd};

  // Writeback happens during the single WB cycle; the op register still holds
  // the accepted opcode there, since alu_opcode is only reloaded on accept.
  assign w_wb_en    = (r_state == ST_WB);
  assign w_wb2_en   = w_wb_en && is_wide_op(r_alu_opcode);
  assign w_wb2_addr = r_rd + REG_AW'(1);  // rd=7 wraps the high half to r0

  issue_regfile u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_rs1_addr (w_instr.rs1),
    .o_rs1_data (w_rs1_data),
    .i_rs2_addr (w_instr.rs2),
    .o_rs2_data (w_rs2_data),
    .i_dbg_addr (rd_addr),
    .o_dbg_data (rd_data),
    .i_wb_en    (w_wb_en),
    .i_wb_addr  (r_rd),
    .i_wb_data  (r_res_lo),
    .i_wb2_en   (w_wb2_en),
    .i_wb2_addr (w_wb2_addr),
    .i_wb2_data (r_res_hi),
    .i_ld_en    (ld_en),
    .i_ld_addr  (ld_addr),
    .i_ld_data  (ld_data)
  );

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other, exactly like the flops they become.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_rd          <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_opcode  <= '0;
      r_alu_start   <= 1'b0;
      r_instr_ready <= 1'b0;
      r_busy        <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
      r_tmo_cnt     <= '0;
      r_res_lo      <= '0;
      r_res_hi      <= '0;
      r_retired     <= '0;
    end else begin
      r_alu_start   <= 1'b0;
      r_err_illegal <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // Ready comes up one cycle after reset release, so it reads 0 in reset.
          r_instr_ready <= 1'b1;
          if (w_accept) begin
            if (is_legal_op(w_instr.op)) begin
              r_rd          <= w_instr.rd;
              r_alu_a       <= w_rs1_data;
              r_alu_b       <= w_rs2_data;
              r_alu_opcode  <= w_instr.op;
              r_alu_start   <= 1'b1;
              r_instr_ready <= 1'b0;
              r_busy        <= 1'b1;
              r_state       <= ST_ISSUE;
            end else begin
              r_err_illegal <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_tmo_cnt <= '0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_done) begin
            r_res_lo <= alu_res_lo[15:0];
            r_res_hi <= alu_res_hi[15:0];
            r_state  <= ST_WB;
          end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // This is the TIMEOUT_CYCLES-th cycle in WAIT without done.
            r_err_timeout <= 1'b1;
            r_instr_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        ST_WB: begin
          r_retired     <= r_retired + RETIRE_W'(1);
          r_instr_ready <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = r_instr_ready;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_opcode  = r_alu_opcode;
  assign alu_start   = r_alu_start;
  assign busy        = r_busy;
  assign err_illegal = r_err_illegal;
  assign err_timeout = r_err_timeout;
  assign retired     = r_retired;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural alu attached.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int TMO = 64;
  localparam int RW  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [2:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_opcode;
  logic        alu_start;
  logic [16:0] alu_res_lo, alu_res_hi;
  logic        alu_done;
  logic        busy, err_illegal, err_timeout;
  logic [RW-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.TIMEOUT_CYCLES(TMO), .RETIRE_W(RW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_start   (alu_start),
    .alu_res_lo  (alu_res_lo),
    .alu_res_hi  (alu_res_hi),
    .alu_done    (alu_done),
    .busy        (busy),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout),
    .retired     (retired)
  );

  // Behavioural alu: answers one cycle after seeing start, unless withheld.
  logic        withhold_done = 1'b0;
  logic        stray_done    = 1'b0;
  logic        m_done;
  logic [31:0] m_prod;
  assign m_prod   = alu_a * alu_b;
  assign alu_done = m_done | stray_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_done     <= 1'b0;
      alu_res_lo <= '0;
      alu_res_hi <= '0;
    end else begin
      m_done <= 1'b0;
      if (alu_start && !withhold_done) begin
        m_done <= 1'b1;
        case (alu_opcode)
          OP_ADD: begin alu_res_lo <= {1'b0, alu_a} + {1'b0, alu_b}; alu_res_hi <= '0; end
          OP_SUB: begin alu_res_lo <= {1'b0, alu_a} - {1'b0, alu_b}; alu_res_hi <= '0; end
          OP_MUL: begin alu_res_lo <= {1'b0, m_prod[15:0]}; alu_res_hi <= {1'b0, m_prod[31:16]}; end
          default: begin
            alu_res_lo <= (alu_b != 0) ? {1'b0, alu_a / alu_b} : 17'h0ffff;
            alu_res_hi <= (alu_b != 0) ? {1'b0, alu_a % alu_b} : {1'b0, alu_a};
          end
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'h0};
  endfunction

  task automatic ld(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic rf_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    rd_addr = a;
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200 && !instr_ready; i++) tick();
    check("ready_within_bound", 32'(instr_ready), 32'd1);
  endtask

  // Leaves the bench in the ISSUE cycle of the accepted instruction.
  task automatic issue(input logic [15:0] ins);
    wait_ready();
    instr_valid = 1'b1; instr = ins;
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    logic [RW-1:0] exp_ret;
    exp_ret = '0;

    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(instr_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(alu_start), 0);
    check("rst_retired", 32'(retired), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    reset = 1'b0;
    tick();
    check("rst_ready_after", 32'(instr_ready), 1);

    // ---- 1: add r0 = r1 + r2, latency
    ld(3'd1, 16'h0005);
    ld(3'd2, 16'h0003);
    rf_chk("t1_ld_r1", 3'd1, 16'h0005);
    instr_valid = 1'b1; instr = mk(OP_ADD, 3'd0, 3'd1, 3'd2);
    tick();                               // accept edge T; now in T+1
    instr_valid = 1'b0;
    check("t1_start", 32'(alu_start), 1);
    check("t1_a", 32'(alu_a), 32'h5);
    check("t1_b", 32'(alu_b), 32'h3);
    check("t1_op", 32'(alu_opcode), 0);
    check("t1_busy", 32'(busy), 1);
    check("t1_ready_low", 32'(instr_ready), 0);
    tick();                               // T+2
    check("t1_start_pulse", 32'(alu_start), 0);
    tick();                               // T+3 (WB)
    rf_chk("t1_r0_before_wb", 3'd0, 16'h0000);
    tick();                               // T+4
    exp_ret++;
    rf_chk("t1_r0", 3'd0, 16'h0008);
    check("t1_retired", 32'(retired), 32'(exp_ret));
    check("t1_ready_t4", 32'(instr_ready), 1);

    // ---- 6a: WB beats same-cycle ld
    ld(3'd0, 16'h1111);
    rf_chk("t6_ld_r0", 3'd0, 16'h1111);
    instr_valid = 1'b1; instr = mk(OP_ADD, 3'd0, 3'd1, 3'd2);
    tick();
    instr_valid = 1'b0;
    tick();                               // T+2
    tick();                               // T+3 (WB)
    ld_en = 1'b1; ld_addr = 3'd0; ld_data = 16'hFFFF;
    tick();
    ld_en = 1'b0;
    exp_ret++;
    rf_chk("t6_wb_wins", 3'd0, 16'h0008);

    // ---- 2: mul r6/r7, valid held high, operands sampled at accept
    ld(3'd1, 16'h1234);
    ld(3'd2, 16'h0100);
    instr_valid = 1'b1; instr = mk(OP_MUL, 3'd6, 3'd1, 3'd2);
    tick();                               // T+1
    check("t2_start", 32'(alu_start), 1);
    check("t2_op", 32'(alu_opcode), 32'(OP_MUL));
    check("t2_a", 32'(alu_a), 32'h1234);
    instr = mk(OP_SUB, 3'd5, 3'd1, 3'd2);
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'hAAAA;
    tick();                               // T+2
    ld_en = 1'b0;
    check("t2_a_held", 32'(alu_a), 32'h1234);
    check("t2_op_held", 32'(alu_opcode), 32'(OP_MUL));
    check("t2_ready_wait", 32'(instr_ready), 0);
    check("t2_no_restart", 32'(alu_start), 0);
    tick();                               // T+3 (WB)
    check("t2_busy_wb", 32'(busy), 1);
    check("t2_ready_wb", 32'(instr_ready), 0);
    tick();                               // T+4
    exp_ret++;
    check("t2_ready_idle", 32'(instr_ready), 1);
    check("t2_busy_idle", 32'(busy), 0);
    rf_chk("t2_r6", 3'd6, 16'h3400);
    rf_chk("t2_r7", 3'd7, 16'h0012);
    check("t2_retired", 32'(retired), 32'(exp_ret));
    tick();                               // held sub accepted at end of T+4
    instr_valid = 1'b0;
    check("t2_sub_start", 32'(alu_start), 1);
    check("t2_sub_op", 32'(alu_opcode), 32'(OP_SUB));
    check("t2_sub_a", 32'(alu_a), 32'hAAAA);
    wait_ready();
    exp_ret++;
    rf_chk("t2_r5", 3'd5, 16'hA9AA);
    check("t2_sub_retired", 32'(retired), 32'(exp_ret));

    // ---- 3: div into r7, remainder wraps to r0
    ld(3'd3, 16'd100);
    ld(3'd4, 16'd7);
    issue(mk(OP_DIV, 3'd7, 3'd3, 3'd4));
    wait_ready();
    exp_ret++;
    rf_chk("t3_quot", 3'd7, 16'd14);
    rf_chk("t3_rem_wrap", 3'd0, 16'd2);
    check("t3_retired", 32'(retired), 32'(exp_ret));

    // ---- 4: illegal op
    issue(mk(3'b101, 3'd2, 3'd3, 3'd4));
    check("t4_illegal", 32'(err_illegal), 1);
    check("t4_no_start", 32'(alu_start), 0);
    check("t4_not_busy", 32'(busy), 0);
    tick();
    check("t4_illegal_pulse", 32'(err_illegal), 0);
    check("t4_no_start2", 32'(alu_start), 0);
    rf_chk("t4_r2_kept", 3'd2, 16'h0100);
    check("t4_retired", 32'(retired), 32'(exp_ret));

    // ---- stray done outside WAIT is ignored
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    tick();
    check("stray_busy", 32'(busy), 0);
    check("stray_retired", 32'(retired), 32'(exp_ret));
    rf_chk("stray_r0", 3'd0, 16'd2);

    // ---- 5: timeout after exactly TMO cycles in WAIT
    withhold_done = 1'b1;
    issue(mk(OP_ADD, 3'd3, 3'd3, 3'd4)); // now T+1 (ISSUE)
    repeat (TMO) tick();                 // last WAIT cycle, T+TMO+1
    check("t5_busy_last_wait", 32'(busy), 1);
    check("t5_no_timeout_yet", 32'(err_timeout), 0);
    tick();
    check("t5_timeout", 32'(err_timeout), 1);
    check("t5_idle", 32'(busy), 0);
    check("t5_ready", 32'(instr_ready), 1);
    rf_chk("t5_r3_kept", 3'd3, 16'd100);
    check("t5_retired", 32'(retired), 32'(exp_ret));
    withhold_done = 1'b0;
    issue(mk(OP_ADD, 3'd1, 3'd3, 3'd4));
    wait_ready();
    exp_ret++;
    rf_chk("t5_after_r1", 3'd1, 16'd107);
    check("t5_sticky", 32'(err_timeout), 1);
    check("t5_retired2", 32'(retired), 32'(exp_ret));

    // ---- 6b: reset during WAIT of a mul
    withhold_done = 1'b1;
    issue(mk(OP_MUL, 3'd6, 3'd3, 3'd4));
    tick();                               // WAIT
    check("t6r_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("t6r_start", 32'(alu_start), 0);
    check("t6r_a", 32'(alu_a), 0);
    check("t6r_b", 32'(alu_b), 0);
    check("t6r_op", 32'(alu_opcode), 0);
    check("t6r_busy0", 32'(busy), 0);
    check("t6r_ready0", 32'(instr_ready), 0);
    check("t6r_timeout0", 32'(err_timeout), 0);
    check("t6r_illegal0", 32'(err_illegal), 0);
    check("t6r_retired0", 32'(retired), 0);
    rf_chk("t6r_r3_cleared", 3'd3, 16'h0000);
    tick();
    reset = 1'b0;
    withhold_done = 1'b0;
    tick();
    check("t6r_idle_ready", 32'(instr_ready), 1);
    check("t6r_idle_busy", 32'(busy), 0);
    rf_chk("t6r_r6_no_wb", 3'd6, 16'h0000);

    // ---- reset while alu_start is high drops it asynchronously
    issue(mk(OP_ADD, 3'd0, 3'd1, 3'd2));
    check("t6s_start_high", 32'(alu_start), 1);
    reset = 1'b1;
    #1;
    check("t6s_start_drop", 32'(alu_start), 0);
    reset = 1'b0;
    tick();
    tick();
    check("t6s_ready", 32'(instr_ready), 1);
    check("t6s_retired", 32'(retired), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
